// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with a fetch starvation bound.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic        d_valid,
    output logic [31:0] if_rdata,
    output logic [31:0] d_rdata,
    output logic        stall
);
    localparam int CW = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    localparam logic [1:0] IDLE = 2'd0, GNT_IF = 2'd1, GNT_D = 2'd2;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [2:0]    mem_size_q, mem_size_d;
    logic          grant_d, grant_if, done;
    always_comb begin
        grant_d     = (state_q == IDLE) & d_req & (~if_req | (starve_q != LIMIT));
        grant_if    = (state_q == IDLE) & if_req & ~grant_d;
        done        = (state_q != IDLE) & mem_ready;
        state_d     = grant_d ? GNT_D : grant_if ? GNT_IF : done ? IDLE : state_q;
        starve_d    = grant_if ? '0 : (grant_d & if_req & (starve_q != LIMIT)) ? starve_q + CW'(1) : starve_q;
        mem_req_d   = grant_d | grant_if | (mem_req_q & ~done);
        mem_we_d    = grant_d ? d_we : grant_if ? 1'b0 : mem_we_q;
        mem_addr_d  = grant_d ? d_addr : grant_if ? if_addr : mem_addr_q;
        mem_wdata_d = grant_d ? d_wdata : grant_if ? 32'd0 : mem_wdata_q;
        mem_size_d  = grant_d ? d_size : grant_if ? 3'b010 : mem_size_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
        end
    end
    // A completion seen while reset is held belongs to an abandoned transaction.
    assign if_valid  = ~rst & (state_q == GNT_IF) & mem_ready;
    assign d_valid   = ~rst & (state_q == GNT_D) & mem_ready;
    assign if_rdata  = if_valid ? mem_rdata : 32'd0;
    assign d_rdata   = d_valid ? mem_rdata : 32'd0;
    assign stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
endmodule
